// File: rtl/seg_scan_ctrl_if.sv
// Host-side bus for the 7-segment scan controller: register-file writes,
// scan enable and the per-digit outputs toward the segment decoder.
// Optional macro SEG_SCAN_BRIGHT_EN adds the 4-bit brightness input.
interface seg_scan_ctrl_if;
    logic       en;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_data;
    logic [3:0] dig_sel;
    logic       dig_en;
    logic [3:0] nibble;
    logic       dp;
    logic       frame_tick;
`ifdef SEG_SCAN_BRIGHT_EN
    logic [3:0] bright;

    modport master (
        output en, wr_en, wr_addr, wr_data, bright,
        input  dig_sel, dig_en, nibble, dp, frame_tick
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, bright,
        output dig_sel, dig_en, nibble, dp, frame_tick
    );
`else
    modport master (
        output en, wr_en, wr_addr, wr_data,
        input  dig_sel, dig_en, nibble, dp, frame_tick
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data,
        output dig_sel, dig_en, nibble, dp, frame_tick
    );
`endif
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment refresh controller. Each digit slot is
// PRESCALE cycles: BLANK_CYCLES with the digit gated off (anti-ghosting),
// then the show phase. The digit's {dp, nibble} is latched once per slot
// on BLANK entry, so host writes land on the next visit to that digit.
// Optional macro SEG_SCAN_BRIGHT_EN: PWM the show phase in 16 steps.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK_CYCLES - 1);
    localparam logic [3:0]    LAST_DIG   = 4'(NUM_DIGITS - 1);
    localparam logic [4:0]    ND         = 5'(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          slot_end;
    logic          enter_blank;

    logic [4:0]    regfile [16];

    logic [3:0]    dig_sel_q, dig_sel_d;
    logic          dig_en_q, dig_en_d;
    logic [3:0]    nibble_q;
    logic          dp_q;
    logic          frame_tick_q, frame_tick_d;

`ifdef SEG_SCAN_BRIGHT_EN
    localparam int W = (PRESCALE - BLANK_CYCLES) / 16;
    logic [3:0]    bright_q;
    logic [CW-1:0] show_lim;

    // Lit length inside the show phase for the brightness captured this slot
    always_comb begin
        show_lim = CW'((32'(bright_q) + 32'd1) * W);
    end

    // Capture brightness once per slot so a slot never changes duty mid-way
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bright_q <= 4'd0;
        else if (enter_blank)
            bright_q <= bus.bright;
    end
`endif

    // State and phase counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: phase lengths come from the counter; en low always idles
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        slot_end   = 1'b0;
        if (!bus.en) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = BLANK;
                    cnt_next   = '0;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_next = SHOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_next = BLANK;
                        cnt_next   = '0;
                        slot_end   = 1'b1;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
        enter_blank = bus.en && ((state == IDLE) || slot_end);
    end

    // Output next-values: digit advance with wrap pulse and the lit gate
    always_comb begin
        dig_sel_d    = dig_sel_q;
        frame_tick_d = 1'b0;
        if (slot_end) begin
            if (dig_sel_q == LAST_DIG) begin
                dig_sel_d    = 4'd0;
                frame_tick_d = 1'b1;
            end else begin
                dig_sel_d = dig_sel_q + 4'd1;
            end
        end
`ifdef SEG_SCAN_BRIGHT_EN
        dig_en_d = (state_next == SHOW) && (cnt_next < show_lim);
`else
        dig_en_d = (state_next == SHOW);
`endif
    end

    // Registered outputs; digit data is latched for the slot being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_sel_q    <= 4'd0;
            dig_en_q     <= 1'b0;
            nibble_q     <= 4'd0;
            dp_q         <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            dig_sel_q    <= dig_sel_d;
            dig_en_q     <= dig_en_d;
            frame_tick_q <= frame_tick_d;
            if (enter_blank) begin
                nibble_q <= regfile[dig_sel_d][3:0];
                dp_q     <= regfile[dig_sel_d][4];
            end
        end
    end

    // Host register file; addresses beyond the scanned digits are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                regfile[i] <= 5'd0;
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < ND)) begin
            regfile[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.dig_sel    = dig_sel_q;
    assign bus.dig_en     = dig_en_q;
    assign bus.nibble     = nibble_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random writes/enables,
// checked every cycle against a slot-position reference model.
// Optional macro SEG_SCAN_BRIGHT_EN switches to PRESCALE=34 and PWM checks.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
`ifdef SEG_SCAN_BRIGHT_EN
    localparam int P = 34;
`else
    localparam int P = 8;
`endif
    localparam int B       = 2;
    localparam int SHOWLEN = P - B;
    localparam int W       = SHOWLEN / 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .PRESCALE    (P),
        .BLANK_CYCLES(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model: whether scanning, position inside the current slot,
    // current digit, register contents and the data latched for this slot.
    bit         mRun;
    int         mPos;
    int         mDig;
    logic [4:0] mRegs [16];
    logic [4:0] mLatch;
    int         mBright;
    bit         mTick;

    int vectors     = 0;
    int miscompares = 0;
    int brightVal   = 0;

    task automatic modelReset();
        mRun = 0; mPos = 0; mDig = 0; mLatch = 5'd0; mBright = 0; mTick = 0;
        for (int i = 0; i < 16; i++) mRegs[i] = 5'd0;
    endtask

    task automatic modelStep(input bit e, input bit we, input int a,
                             input logic [4:0] d, input int br);
        mTick = 0;
        if (!e) begin
            mRun = 0;
        end else if (!mRun) begin
            mRun = 1; mPos = 0; mLatch = mRegs[mDig]; mBright = br;
        end else begin
            mPos++;
            if (mPos == P) begin
                mPos = 0;
                if (mDig == ND - 1) begin
                    mDig = 0; mTick = 1;
                end else begin
                    mDig++;
                end
                mLatch = mRegs[mDig]; mBright = br;
            end
        end
        if (we && a < ND) mRegs[a] = d;
    endtask

    function automatic bit expDigEn();
        int lim;
`ifdef SEG_SCAN_BRIGHT_EN
        lim = (mBright + 1) * W;
`else
        lim = SHOWLEN;
`endif
        return mRun && (mPos >= B) && ((mPos - B) < lim);
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".dig_sel"},    {4'd0, bus.dig_sel},    8'(mDig));
        cmp({tag, ".dig_en"},     {7'd0, bus.dig_en},     {7'd0, expDigEn()});
        cmp({tag, ".nibble"},     {4'd0, bus.nibble},     {4'd0, mLatch[3:0]});
        cmp({tag, ".dp"},         {7'd0, bus.dp},         {7'd0, mLatch[4]});
        cmp({tag, ".frame_tick"}, {7'd0, bus.frame_tick}, {7'd0, mTick});
    endtask

    task automatic applyStimulus(input bit e, input bit we, input int a, input logic [4:0] d);
        bus.en      = e;
        bus.wr_en   = we;
        bus.wr_addr = a[3:0];
        bus.wr_data = d;
`ifdef SEG_SCAN_BRIGHT_EN
        bus.bright  = brightVal[3:0];
`endif
        @(posedge clk);
        modelStep(e, we, a, d, brightVal);
        #1;
        checkOutput("cycle");
    endtask

    task automatic runCycles(input int n, input bit e);
        repeat (n) applyStimulus(e, 1'b0, 0, 5'd0);
    endtask

    task automatic runUntil(input int dig, input int pos);
        bit found = 0;
        for (int i = 0; i < 4 * ND * P; i++) begin
            if (mRun && mDig == dig && mPos == pos) begin
                found = 1;
                break;
            end
            applyStimulus(1'b1, 1'b0, 0, 5'd0);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $error("[TB] FAIL wait_slot: digit %0d pos %0d not reached, at digit %0d pos %0d",
                   dig, pos, mDig, mPos);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 5'd0;
`ifdef SEG_SCAN_BRIGHT_EN
        bus.bright  = 4'd0;
`endif
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b0;

        // Scan from reset with writes to digit 2 and to an out-of-range address
        applyStimulus(1'b1, 1'b1, 2, 5'h1A);
        applyStimulus(1'b1, 1'b1, 9, 5'h1F);
        runCycles(ND * P + 4, 1'b1);

        // Write digit 1 during its own show phase: visible only on next visit
        runUntil(1, B + 2);
        applyStimulus(1'b1, 1'b1, 1, 5'h05);
        runCycles(ND * P + 2, 1'b1);

        // Drop enable mid-show of digit 3, then resume on the same digit
        runUntil(3, B + 3);
        runCycles(3, 1'b0);
        runCycles(P + 4, 1'b1);

        // Asynchronous reset mid-show, checked before the next clock edge
        runUntil(2, B + 1);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_rst");
        #2;
        rst = 1'b0;
        runCycles(ND * P + 2, 1'b1);

`ifdef SEG_SCAN_BRIGHT_EN
        // Brightness extremes and midpoint, one frame each
        brightVal = 0;
        runCycles(ND * P, 1'b1);
        brightVal = 15;
        runCycles(ND * P, 1'b1);
        brightVal = 7;
        runCycles(ND * P, 1'b1);
`endif

        // Random writes (any address), rare enable drops, random brightness
        for (int i = 0; i < 400; i++) begin
            bit         e;
            bit         we;
            int         a;
            logic [4:0] d;
            e  = ($urandom_range(0, 39) != 0);
            we = ($urandom_range(0, 3) == 0);
            a  = $urandom_range(0, 15);
            d  = 5'($urandom);
`ifdef SEG_SCAN_BRIGHT_EN
            if ($urandom_range(0, 7) == 0) brightVal = $urandom_range(0, 15);
`endif
            applyStimulus(e, we, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
